// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL lock supervisor and staggered per-domain reset sequencer
// Optional lock-loss counter and loss_cnt port: define PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
module pll_lock_supervisor #(
  parameter int NUM_CH           = 5,
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int STAGGER_CYC      = 8,
  parameter int CNT_W            = 8
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  output logic              pll_rst,
  output logic [NUM_CH-1:0] ch_rst,
  output logic              all_ready,
  output logic [1:0]        state,
  output logic              timeout_err
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
  ,
  output logic [CNT_W-1:0]  loss_cnt
`endif
);

  // Counter widths: each counter holds 0..limit and never wraps inside its state.
  localparam int PW = $clog2(RST_PULSE_CYC + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYC + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYC + 1);
  localparam int GW = $clog2(NUM_CH * STAGGER_CYC + 1);

  localparam logic [PW-1:0] PULSE_END  = PW'(RST_PULSE_CYC);
  localparam logic [SW-1:0] STABLE_END = SW'(LOCK_STABLE_CYC);
  localparam logic [TW-1:0] TMO_END    = TW'(LOCK_TIMEOUT_CYC);

  // Reject illegal parameter sets at elaboration.
  if (NUM_CH < 1 || NUM_CH > 16 || RST_PULSE_CYC < 1 || LOCK_STABLE_CYC < 1 ||
      LOCK_TIMEOUT_CYC <= LOCK_STABLE_CYC || STAGGER_CYC < 1 || CNT_W < 1) begin : g_bad_params
    $error("pll_lock_supervisor: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_RESET_PLL = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t fsm_q, fsm_d;

  logic meta, lk;

  logic [PW-1:0] pulse_q, pulse_d, pulse_inc;
  logic [SW-1:0] stable_q, stable_d, stable_inc;
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  logic [GW-1:0] stg_q, stg_d, stg_inc;

  logic [NUM_CH-1:0] ch_rst_d;
  logic              timeout_set;
  logic              lock_lost;

  assign pulse_inc  = pulse_q + 1'b1;
  assign stable_inc = stable_q + 1'b1;
  assign tmo_inc    = tmo_q + 1'b1;
  assign stg_inc    = stg_q + 1'b1;

  assign state = fsm_q;

  // Two-flop synchroniser for the asynchronous PLL locked output.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      lk   <= 1'b0;
    end else begin
      meta <= pll_locked;
      lk   <= meta;
    end
  end

  // Next-state, counter and channel-reset decisions.
  always_comb begin
    fsm_d       = fsm_q;
    pulse_d     = pulse_q;
    stable_d    = stable_q;
    tmo_d       = tmo_q;
    stg_d       = stg_q;
    ch_rst_d    = ch_rst;
    timeout_set = 1'b0;
    lock_lost   = 1'b0;

    case (fsm_q)
      S_RESET_PLL: begin
        ch_rst_d = '1;
        pulse_d  = pulse_inc;
        if (pulse_inc == PULSE_END) begin
          fsm_d = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        ch_rst_d = '1;
        stable_d = lk ? stable_inc : '0;
        tmo_d    = tmo_inc;
        // Accepting lock beats a timeout landing on the same cycle.
        if (lk && stable_inc == STABLE_END) begin
          fsm_d = S_RELEASE;
        end else if (tmo_inc == TMO_END) begin
          timeout_set = 1'b1;
          fsm_d       = S_RESET_PLL;
        end
      end
      S_RELEASE: begin
        if (!lk) begin
          lock_lost = 1'b1;
        end else if (ch_rst == '0) begin
          // Last channel went out one cycle ago; all_ready follows it by a cycle.
          fsm_d = S_RUN;
        end else begin
          stg_d = stg_inc;
          for (int i = 0; i < NUM_CH; i++) begin
            if (int'(stg_inc) == (i + 1) * STAGGER_CYC) begin
              ch_rst_d[i] = 1'b0;
            end
          end
        end
      end
      default: begin
        ch_rst_d = '0;
        if (!lk) begin
          lock_lost = 1'b1;
        end
      end
    endcase

    // Lock loss wins over any release scheduled for this cycle.
    if (lock_lost) begin
      fsm_d    = S_RESET_PLL;
      ch_rst_d = '1;
    end

    // Every fresh entry to RESET_PLL starts all counters from zero.
    if (fsm_d == S_RESET_PLL && fsm_q != S_RESET_PLL) begin
      pulse_d  = '0;
      stable_d = '0;
      tmo_d    = '0;
      stg_d    = '0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      fsm_q       <= S_RESET_PLL;
      pulse_q     <= '0;
      stable_q    <= '0;
      tmo_q       <= '0;
      stg_q       <= '0;
      pll_rst     <= 1'b1;
      ch_rst      <= '1;
      all_ready   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      pulse_q   <= pulse_d;
      stable_q  <= stable_d;
      tmo_q     <= tmo_d;
      stg_q     <= stg_d;
      pll_rst   <= (fsm_d == S_RESET_PLL);
      ch_rst    <= ch_rst_d;
      all_ready <= (fsm_d == S_RUN);
      if (timeout_set) begin
        timeout_err <= 1'b1;
      end
    end
  end

`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
  // Saturating count of lock losses seen in RELEASE or RUN.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      loss_cnt <= '0;
    end else if (lock_lost && loss_cnt != '1) begin
      loss_cnt <= loss_cnt + 1'b1;
    end
  end
`endif

endmodule
